// File: rtl/stage_1_input_scheduler_if.sv
// Symbol-source / stage-1 bundle for the stage-1 input scheduler.
// The slave modport is the scheduler; the master modport is the environment (sources + stage 1).
interface stage_1_input_scheduler_if #(
    parameter int RANGE_WIDTH  = 16,
    parameter int SYMBOL_WIDTH = 4
);
    logic                                frame_start;
    logic [1:0]                          req_valid;
    logic [1:0]                          req_ready;
    logic [1:0]                          req_last;
    logic [1:0][RANGE_WIDTH-1:0]         req_fl;
    logic [1:0][RANGE_WIDTH-1:0]         req_fh;
    logic [1:0][SYMBOL_WIDTH-1:0]        req_symbol;
    logic [1:0][SYMBOL_WIDTH:0]          req_nsyms;
    logic [1:0]                          req_bool;
    logic                                out_stall;
    logic                                out_valid;
    logic [RANGE_WIDTH-1:0]              out_fl;
    logic [RANGE_WIDTH-1:0]              out_fh;
    logic [SYMBOL_WIDTH-1:0]             out_symbol;
    logic [SYMBOL_WIDTH:0]               out_nsyms;
    logic                                out_bool_flag;
    logic                                out_src;
    logic                                flush_pulse;
    logic                                busy;
    logic                                err_sticky;

    modport slave (
        input  frame_start, req_valid, req_last, req_fl, req_fh, req_symbol, req_nsyms,
               req_bool, out_stall,
        output req_ready, out_valid, out_fl, out_fh, out_symbol, out_nsyms, out_bool_flag,
               out_src, flush_pulse, busy, err_sticky
    );

    modport master (
        output frame_start, req_valid, req_last, req_fl, req_fh, req_symbol, req_nsyms,
               req_bool, out_stall,
        input  req_ready, out_valid, out_fl, out_fh, out_symbol, out_nsyms, out_bool_flag,
               out_src, flush_pulse, busy, err_sticky
    );
endinterface

// File: rtl/stage_1_input_scheduler.sv
// Two-source round-robin scheduler feeding the entropy-encoder stage-1 input register.
// Optional SCHED_NSYMS_CHECK_EN drops illegal packets (NSYMS range / SYMBOL bound) and flags err_sticky.
module stage_1_input_scheduler #(
    parameter int RANGE_WIDTH  = 16,
    parameter int SYMBOL_WIDTH = 4
) (
    input  logic                    clk_sched,
    input  logic                    reset_sched,
    stage_1_input_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_t;

    state_t     state, state_nxt;
    logic [1:0] done;
    logic       rr_ptr;
    logic [1:0] eligible, grant;
    logic       can_load, xfer, sel, load, frame_go;

    assign frame_go = bus.frame_start && (state == IDLE || state == DONE);
    assign can_load = !bus.out_valid || !bus.out_stall;

    for (genvar i = 0; i < 2; i++) begin : g_src
        assign eligible[i]      = bus.req_valid[i] && !done[i];
        assign bus.req_ready[i] = (state == ACTIVE) && can_load && !done[i] && grant[i];
    end

    // Contention goes to rr_ptr; a lone requester always wins.
    always_comb begin
        grant = eligible;
        if (&eligible)
            grant = rr_ptr ? 2'b10 : 2'b01;
    end

    assign xfer = |(bus.req_valid & bus.req_ready);
    assign sel  = grant[1];

`ifdef SCHED_NSYMS_CHECK_EN
    localparam logic [SYMBOL_WIDTH:0] NS_MIN = (SYMBOL_WIDTH+1)'(2);
    localparam logic [SYMBOL_WIDTH:0] NS_MAX = (SYMBOL_WIDTH+1)'(16);

    logic sel_legal;
    logic err_q;

    assign sel_legal = (bus.req_nsyms[sel] >= NS_MIN) && (bus.req_nsyms[sel] <= NS_MAX) &&
                       !(bus.req_bool[sel] && ({1'b0, bus.req_symbol[sel]} >= bus.req_nsyms[sel]));
    assign load = xfer && sel_legal;

    always_ff @(posedge clk_sched or posedge reset_sched) begin
        if (reset_sched)
            err_q <= 1'b0;
        else if (frame_go)
            err_q <= 1'b0;
        else if (xfer && !sel_legal)
            err_q <= 1'b1;
    end
    assign bus.err_sticky = err_q;
`else
    assign load           = xfer;
    assign bus.err_sticky = 1'b0;
`endif

    // Done flags and round-robin pointer
    always_ff @(posedge clk_sched or posedge reset_sched) begin
        if (reset_sched) begin
            done   <= 2'b00;
            rr_ptr <= 1'b0;
        end else begin
            if (frame_go)
                done <= 2'b00;
            else if (xfer && bus.req_last[sel])
                done[sel] <= 1'b1;
            if (xfer && &eligible)
                rr_ptr <= ~sel;
        end
    end

    // Stage-1 input register: hold under stall, drop valid once consumed without refill.
    always_ff @(posedge clk_sched or posedge reset_sched) begin
        if (reset_sched) begin
            bus.out_valid     <= 1'b0;
            bus.out_fl        <= '0;
            bus.out_fh        <= '0;
            bus.out_symbol    <= '0;
            bus.out_nsyms     <= '0;
            bus.out_bool_flag <= 1'b0;
            bus.out_src       <= 1'b0;
        end else if (load) begin
            bus.out_valid     <= 1'b1;
            bus.out_fl        <= bus.req_fl[sel];
            bus.out_fh        <= bus.req_fh[sel];
            bus.out_symbol    <= bus.req_symbol[sel];
            bus.out_nsyms     <= bus.req_nsyms[sel];
            bus.out_bool_flag <= bus.req_bool[sel];
            bus.out_src       <= sel;
        end else if (!bus.out_stall) begin
            bus.out_valid     <= 1'b0;
        end
    end

    always_ff @(posedge clk_sched or posedge reset_sched) begin
        if (reset_sched)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Flush only once the last packet has left the register, so flush never overlaps out_valid.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.frame_start) state_nxt = ACTIVE;
            ACTIVE:     if (done == 2'b11 && (!bus.out_valid || (!bus.out_stall && !load)))
                            state_nxt = FLUSH;
            FLUSH:      state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.flush_pulse = (state == FLUSH);
        bus.busy        = (state == ACTIVE) || (state == FLUSH);
    end
endmodule
